// File: rtl/regex_stream_ctx_mgr.sv
// regex_stream_ctx_mgr
// Per-stream context manager for one DFA regex engine. On each packet start it
// restores the saved engine state of that stream (or zero for a stream with no
// saved context). At packet end it saves the engine state and updates the
// saturating global and per-stream match-packet counters. A clear sweep wipes
// every stream context and per-stream counter, one stream per cycle.
//
// Handshake: sop is accepted only when busy is low (FSM in IDLE). A sop seen
// while busy is dropped and reported by a one-cycle sop_drop pulse on the
// following cycle. eng_state_in_vld is a one-cycle strobe with no back-pressure.
// eop is only honoured in SCAN, so the earliest legal eop is two cycles after sop.
module regex_stream_ctx_mgr #(
    parameter int STATE_W = 11,
    parameter int SID_W   = 6,
    parameter int COUNT_W = 16,
    parameter int SCNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sop,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               enable,
    input  logic               eop,
    input  logic [STATE_W-1:0] eng_state_out,
    input  logic               eng_accept,
    output logic [STATE_W-1:0] eng_state_in,
    output logic               eng_state_in_vld,
    output logic               fired,
    output logic               busy,
    output logic               sop_drop,
    input  logic               clear_req,
    output logic [COUNT_W-1:0] total_count,
    input  logic [SID_W-1:0]   rd_id,
    output logic [SCNT_W-1:0]  rd_count
);

    localparam int NUM_STREAMS = 2 ** SID_W;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_LOAD   = 3'd2,
        S_SCAN   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SID_W-1:0]    clr_idx;
    logic [SID_W-1:0]    sid_r;
    logic                enable_r;
    logic                clear_pend;
    logic                fired_next;
    logic                start_clear;
    logic [NUM_STREAMS-1:0] valid_q;
    logic [STATE_W-1:0]  ctx_mem  [NUM_STREAMS];
    logic [SCNT_W-1:0]   scnt_mem [NUM_STREAMS];

    // An accept in the eop cycle still counts for this packet.
    assign fired_next  = fired | eng_accept;
    // A clear leaves IDLE only when no sop competes for the same cycle.
    assign start_clear = (state == S_IDLE) && !sop && (clear_req || clear_pend);

    // Next-state logic; the sweep ends once the last stream index is cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR:  if (clr_idx == SID_W'(NUM_STREAMS - 1)) state_nxt = S_IDLE;
            S_IDLE: begin
                if (sop)              state_nxt = S_LOAD;
                else if (start_clear) state_nxt = S_CLEAR;
            end
            S_LOAD:   state_nxt = S_SCAN;
            S_SCAN:   if (eop) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_CLEAR;
        endcase
    end

    // Engine load port and busy flag, derived from the current state only.
    always_comb begin
        busy             = (state != S_IDLE);
        eng_state_in_vld = (state == S_LOAD);
        eng_state_in     = '0;
        if (state == S_LOAD && valid_q[sid_r]) eng_state_in = ctx_mem[sid_r];
    end

    // Control state: FSM, packet latches, fired flag, valid bits, global count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLEAR;
            clr_idx     <= '0;
            sid_r       <= '0;
            enable_r    <= 1'b0;
            clear_pend  <= 1'b0;
            fired       <= 1'b0;
            sop_drop    <= 1'b0;
            total_count <= '0;
            valid_q     <= '0;
        end else begin
            state    <= state_nxt;
            sop_drop <= sop && busy;

            if (start_clear)
                clear_pend <= 1'b0;
            else if (clear_req && state != S_CLEAR)
                clear_pend <= 1'b1;

            case (state)
                S_CLEAR: begin
                    valid_q[clr_idx] <= 1'b0;
                    clr_idx          <= clr_idx + SID_W'(1);
                end
                S_IDLE: begin
                    if (sop) begin
                        sid_r    <= stream_id;
                        enable_r <= enable;
                        fired    <= 1'b0;
                    end else if (start_clear) begin
                        total_count <= '0;
                        clr_idx     <= '0;
                    end
                end
                S_SCAN: begin
                    if (eop) begin
                        if (enable_r) begin
                            valid_q[sid_r] <= 1'b1;
                            fired          <= fired_next;
                            if (fired_next && total_count != '1)
                                total_count <= total_count + COUNT_W'(1);
                        end else begin
                            fired <= 1'b0;
                        end
                    end else if (eng_accept) begin
                        fired <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Context store: engine state saved at eop of an enabled packet.
    always_ff @(posedge clk) begin
        if (state == S_SCAN && eop && enable_r) ctx_mem[sid_r] <= eng_state_out;
    end

    // Per-stream counters: zeroed by the sweep, bumped in COMMIT on a match.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            scnt_mem[clr_idx] <= '0;
        else if (state == S_COMMIT && enable_r && fired && scnt_mem[sid_r] != '1)
            scnt_mem[sid_r] <= scnt_mem[sid_r] + SCNT_W'(1);
    end

    // Registered read port; a same-cycle COMMIT write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (rst) rd_count <= '0;
        else     rd_count <= scnt_mem[rd_id];
    end

endmodule

// File: doc/regex_stream_ctx_mgr.md
Name: regex_stream_ctx_mgr

Overview:
- Generic per-stream context manager for one DFA regex engine in the DPI pipeline.
- Saves and restores engine state per stream ID across packets, and tracks a per-packet "fired" flag.
- Keeps a saturating global match-packet count and saturating per-stream match-packet counters, readable through a read port.
- Successor to the fixed-width per-regex wrappers:
  - widths and stream depth are parametrised;
  - stream-valid tracking is internal, so no new_stream_id input is needed;
  - adds a clear sweep, a busy/drop handshake and a counter read-back port.

Parameters:
STATE_W, 11, engine state width
SID_W, 6, stream ID width; NUM_STREAMS = 2**SID_W
COUNT_W, 16, global count width
SCNT_W, 8, per-stream counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
sop  in  1  packet start; samples stream_id and enable
stream_id  in  SID_W  stream of the packet starting at sop
enable  in  1  regex enabled for this stream (sampled at sop)
eop  in  1  packet end (last char cycle)
eng_state_out  in  STATE_W  engine current state
eng_accept  in  1  engine accept pulse
eng_state_in  out  STATE_W  state to load into engine
eng_state_in_vld  out  1  one-cycle load strobe to engine
fired  out  1  sticky: current/last packet matched
busy  out  1  sop not accepted this cycle
sop_drop  out  1  one-cycle pulse: sop arrived while busy
clear_req  in  1  request to clear all contexts and counters
total_count  out  COUNT_W  saturating count of matched enabled packets
rd_id  in  SID_W  per-stream counter read address
rd_count  out  SCNT_W  per-stream counter, 1-cycle read latency

Behaviour:
- Storage:
  - ctx_mem[NUM_STREAMS] of STATE_W;
  - valid[NUM_STREAMS] flop vector;
  - scnt[NUM_STREAMS] of SCNT_W.
- FSM states: CLEAR, IDLE, LOAD, SCAN, COMMIT.
- Reset (rst=1 at an edge):
  - all outputs 0 except busy=1;
  - valid all 0; total_count 0; fired 0;
  - FSM enters CLEAR with sweep index 0.
- CLEAR:
  - writes scnt[idx]=0 and valid[idx]=0 each cycle;
  - after NUM_STREAMS cycles (idx wraps from NUM_STREAMS-1) goes to IDLE;
  - busy=1 throughout;
  - rst asserted mid-sweep restarts the sweep at 0.
- IDLE:
  - busy=0.
  - sop=1: latch sid/enable, clear fired, go to LOAD.
  - Else if clear_req or clear pending: go to CLEAR, with total_count<=0 on entry.
  - sop has priority over clear_req in the same cycle; the clear stays pending and runs on the next IDLE.
- LOAD (1 cycle, the cycle after sop):
  - eng_state_in = valid[sid] ? ctx_mem[sid] : 0;
  - eng_state_in_vld=1 for exactly this cycle;
  - next state SCAN.
- SCAN:
  - eng_accept=1 sets fired (sticky until next accepted sop or reset).
  - eop=1 at edge:
    - if enable_r: ctx_mem[sid]<=eng_state_out, valid[sid]<=1, total_count<=sat(total_count+fired_next);
    - if !enable_r: fired<=0, no state write;
    - go to COMMIT.
  - fired_next = fired | eng_accept, so an accept in the eop cycle counts.
- COMMIT (1 cycle):
  - if enable_r and fired: scnt[sid]<=sat(scnt[sid]+1);
  - go to IDLE.
- busy=1 in LOAD, SCAN, COMMIT and CLEAR.
- sop while busy: ignored, sop_drop=1 in the following cycle.
- eop outside SCAN: ignored.
- eop in the LOAD cycle: ignored; eop earliest legal at sop+2.
- Saturation: counters stick at all-ones and never wrap.
- Read port:
  - rd_count<=scnt[rd_id] every cycle, one registered cycle of latency;
  - a read of the sid being written in COMMIT returns the pre-write value.
- fired remains visible after COMMIT until the next accepted sop.
- Min packet occupancy is 4 cycles sop-to-IDLE (sop, LOAD, SCAN with eop, COMMIT); back-to-back sop is legal in the cycle after COMMIT.

Test Plan:
- Reset release:
  - busy=1 for exactly 64 cycles (SID_W=6), then 0;
  - total_count=0; rd_count=0 for every rd_id.
- New stream:
  - sop id=5 enable=1 → LOAD cycle drives eng_state_in=0, vld=1 for one cycle;
  - eop with eng_state_out=0x1A3 and no accept → fired=0, total_count=0.
- Restore:
  - second sop id=5 → eng_state_in=0x1A3;
  - eng_accept in the eop cycle → fired=1, total_count=1, rd_id=5 reads 1 two cycles after COMMIT.
- Disabled stream:
  - sop id=7 enable=0, accept mid-packet → fired=1 during SCAN, 0 after eop;
  - ctx_mem[7] unchanged, so the next sop id=7 loads 0.
- Busy and clear:
  - sop during SCAN → sop_drop pulse, FSM unaffected;
  - clear_req while busy → CLEAR begins the first IDLE cycle after COMMIT, total_count=0, prior ids load 0.
- Saturation:
  - SCNT_W=2, four matched packets on id=3 → rd_count=3, not 0;
  - total_count keeps incrementing.
